// File: rtl/avalon_packet_arbiter_pkg.sv
// Shared types, constants and round-robin helper for the packet arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arbiter_pack;

    localparam int DEFAULT_NUM_SOURCES = 4;
    localparam int MAX_SOURCES         = 16;
    localparam int AV_DATA_W           = 32;
    localparam int AV_EMPTY_W          = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arbiter_sm_t;

    // First requester after last_grant, wrapping modulo n. Scanning offsets from the
    // far end down means the nearest requester is the last one written and wins.
    // Returns 0 when nothing requests; callers qualify the result with |req.
    function automatic int unsigned rr_next(input logic [MAX_SOURCES-1:0] req,
                                            input int unsigned            last_grant,
                                            input int unsigned            n);
        int unsigned result;
        int unsigned idx;
        result = 0;
        for (int unsigned off = n; off > 0; off--) begin
            idx = (last_grant + off) % n;
            if (req[idx[3:0]]) begin
                result = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST channel bundle: data, empty, valid, sop, eop forward and rdy backward.
// Latency: n/a (wires only).
// Backpressure: rdy from the sink qualifies valid from the source.
interface avalon_st_if;
    import arbiter_pack::*;

    logic [AV_DATA_W-1:0]  data;
    logic [AV_EMPTY_W-1:0] empty;
    logic                  valid;
    logic                  sop;
    logic                  eop;
    logic                  rdy;

    modport master (output data, empty, valid, sop, eop, input  rdy);
    modport slave  (input  data, empty, valid, sop, eop, output rdy);
endinterface

// File: rtl/avalon_packet_arbiter_picker.sv
// Round-robin picker: first requester after last_idx, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the pick.
module rr_priority_picker
    import arbiter_pack::*;
#(
    parameter int N = DEFAULT_NUM_SOURCES,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_idx,
    output logic [W-1:0] pick_idx,
    output logic         pick_vld
);

    logic [MAX_SOURCES-1:0] req_ext;

    // Widen the request vector to the helper's fixed width and run the search.
    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        pick_vld         = |req;
        pick_idx         = W'(rr_next(req_ext, 32'(last_idx), N));
    end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-granular round-robin arbiter: NUM_SOURCES Avalon-ST sources share one downstream channel.
// Latency: 1 cycle from an eligible sop in IDLE to the first forwarded beat; LOCKED forwarding is combinational.
// Backpressure: arb_msg.rdy reaches only the granted source; every other source sees rdy=0.
module avalon_packet_arbiter
    import arbiter_pack::*;
#(
    parameter int NUM_SOURCES   = DEFAULT_NUM_SOURCES,
    parameter int SRC_IDX_WIDTH = $clog2(NUM_SOURCES)
) (
    input  logic                     clk,
    input  logic                     rst,
    avalon_st_if.slave               src_msg [NUM_SOURCES],
    avalon_st_if.master              arb_msg,
    output logic                     grant_valid,
    output logic [SRC_IDX_WIDTH-1:0] grant_idx,
    output logic                     packet_done
);

    arbiter_sm_t              state_q;
    arbiter_sm_t              state_d;
    logic [SRC_IDX_WIDTH-1:0] grant_idx_q;
    logic [SRC_IDX_WIDTH-1:0] last_grant_q;
    logic [SRC_IDX_WIDTH-1:0] pick_idx;
    logic                     pick_vld;
    logic [NUM_SOURCES-1:0]   eligible;

    // Interface arrays only take constant indices, so flatten them for the muxes.
    logic [AV_DATA_W-1:0]     src_data  [NUM_SOURCES];
    logic [AV_EMPTY_W-1:0]    src_empty [NUM_SOURCES];
    logic                     src_valid [NUM_SOURCES];
    logic                     src_sop   [NUM_SOURCES];
    logic                     src_eop   [NUM_SOURCES];
    logic                     src_rdy   [NUM_SOURCES];

    logic [AV_DATA_W-1:0]     out_data;
    logic [AV_EMPTY_W-1:0]    out_empty;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_eop;
    logic                     down_rdy;
    logic                     eop_acc;

    for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_src
        assign src_data[g]    = src_msg[g].data;
        assign src_empty[g]   = src_msg[g].empty;
        assign src_valid[g]   = src_msg[g].valid;
        assign src_sop[g]     = src_msg[g].sop;
        assign src_eop[g]     = src_msg[g].eop;
        assign src_msg[g].rdy = src_rdy[g];
        // Only a packet start may win arbitration; stray mid-packet beats wait unserved.
        assign eligible[g]    = src_valid[g] & src_sop[g];
    end

    rr_priority_picker #(
        .N (NUM_SOURCES),
        .W (SRC_IDX_WIDTH)
    ) u_picker (
        .req      (eligible),
        .last_idx (last_grant_q),
        .pick_idx (pick_idx),
        .pick_vld (pick_vld)
    );

    assign down_rdy      = arb_msg.rdy;
    assign arb_msg.data  = out_data;
    assign arb_msg.empty = out_empty;
    assign arb_msg.valid = out_valid;
    assign arb_msg.sop   = out_sop;
    assign arb_msg.eop   = out_eop;

    // The owning packet ends on the cycle its eop beat is taken downstream.
    assign eop_acc     = (state_q == LOCKED) && out_valid && down_rdy && out_eop;
    assign packet_done = eop_acc;
    assign grant_valid = (state_q == LOCKED);
    assign grant_idx   = grant_idx_q;

    // State register; an async reset drops the output mid-packet immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: grant from IDLE, release on accepted eop. Never both in one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = LOCKED;
            LOCKED:  if (eop_acc)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant registers: capture the pick on grant, clear the index when the packet ends.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_idx_q  <= '0;
            last_grant_q <= SRC_IDX_WIDTH'(NUM_SOURCES - 1);
        end else if ((state_q == IDLE) && pick_vld) begin
            grant_idx_q  <= pick_idx;
            last_grant_q <= pick_idx;
        end else if (eop_acc) begin
            grant_idx_q  <= '0;
        end
    end

    // Output mux: in LOCKED the granted source is wired straight through both ways.
    always_comb begin
        out_data  = '0;
        out_empty = '0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            src_rdy[i] = 1'b0;
        end
        if (state_q == LOCKED) begin
            out_data              = src_data[grant_idx_q];
            out_empty             = src_empty[grant_idx_q];
            out_valid             = src_valid[grant_idx_q];
            out_sop               = src_sop[grant_idx_q];
            out_eop               = src_eop[grant_idx_q];
            src_rdy[grant_idx_q]  = down_rdy;
        end
    end

endmodule
